// File: rtl/uart_rx_buf_if.sv
// Consumer-side bundle of the UART receive buffer: FIFO head, valid, pop strobe
// and the two error pulses.
interface uart_rx_buf_if;
    logic       rd_en;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rd_en
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rd_en
    );
endinterface

// File: rtl/uart_rx_buf.sv
// 8N1 UART receiver with 16x oversampling and mid-bit sampling, feeding a small
// first-word-fall-through FIFO; framing and overrun errors are 1-cycle pulses.
module uart_rx_buf #(
    parameter int unsigned DIV0       = 1302,
    parameter int unsigned DIV1       = 651,
    parameter int unsigned DIV2       = 326,
    parameter int unsigned DIV3       = 163,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rxd,
    input  logic [1:0]      br_cfg,
    uart_rx_buf_if.master   rx_if
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    function automatic logic [15:0] div_sel(input logic [1:0] cfg);
        case (cfg)
            2'b00:   div_sel = 16'(DIV0);
            2'b01:   div_sel = 16'(DIV1);
            2'b10:   div_sel = 16'(DIV2);
            2'b11:   div_sel = 16'(DIV3);
            default: div_sel = 16'(DIV3);
        endcase
    endfunction

    logic [1:0]       sync_q,     sync_d;
    state_t           state_q,    state_d;
    logic [15:0]      div_cnt_q,  div_cnt_d;
    logic [15:0]      div_lim_q,  div_lim_d;
    logic [3:0]       tick_cnt_q, tick_cnt_d;
    logic [2:0]       bit_cnt_q,  bit_cnt_d;
    logic [7:0]       shift_q,    shift_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q,  overrun_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       rx_data_q,  rx_data_d;

    logic rxd_s;
    logic tick_s;
    logic push_req_s;
    logic pop_s;
    logic full_s;
    logic wr_en_s;

    assign rxd_s  = sync_q[1];
    assign tick_s = (div_cnt_q == (div_lim_q - 16'd1));

    // Synchronizer shift and oversampling divider (held cleared while idle)
    always_comb begin
        sync_d = {sync_q[0], rxd};
        if (state_q == ST_IDLE) begin
            div_cnt_d = 16'd0;
        end else if (tick_s) begin
            div_cnt_d = 16'd0;
        end else begin
            div_cnt_d = div_cnt_q + 16'd1;
        end
    end

    // Frame-recovery next state; push_req_s fires in the stop-sample cycle
    always_comb begin
        state_d     = state_q;
        div_lim_d   = div_lim_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        push_req_s  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tick_cnt_d = 4'd0;
                if (!rxd_s) begin
                    state_d   = ST_START;
                    div_lim_d = div_sel(br_cfg);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = 4'd0;
                        bit_cnt_d  = 3'd0;
                        if (rxd_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        shift_d[bit_cnt_q] = rxd_s;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (tick_cnt_q == 4'd15) begin
                        if (rxd_s) begin
                            push_req_s = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BREAK;
                        end
                    end else begin
                        state_d = ST_STOP;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q;
                end
            end
            ST_BREAK: begin
                if (rxd_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; head byte and valid are precomputed so outputs stay registered
    always_comb begin
        pop_s     = rx_if.rd_en & rx_valid_q;
        full_s    = (count_q == CNT_W'(FIFO_DEPTH));
        wr_en_s   = push_req_s & (~full_s | pop_s);
        overrun_d = push_req_s & full_s & ~pop_s;
        mem_d     = mem_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        rx_valid_d = (count_d != {CNT_W{1'b0}});
        // A push landing on the slot the head is about to occupy bypasses the array
        if (wr_en_s && (wr_ptr_q == rd_ptr_d)) begin
            rx_data_d = shift_q;
        end else if (rx_valid_d) begin
            rx_data_d = mem_q[rd_ptr_d];
        end else begin
            rx_data_d = rx_data_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= 2'b11;
            state_q     <= ST_IDLE;
            div_cnt_q   <= 16'd0;
            div_lim_q   <= 16'(DIV0);
            tick_cnt_q  <= 4'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= 8'd0;
            end
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            rx_valid_q  <= 1'b0;
            rx_data_q   <= 8'd0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            div_lim_q   <= div_lim_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed bench for uart_rx_buf: fast dividers (br_cfg=01 -> 128 clk per bit).
module tb_uart_rx_buf;

    localparam int BIT_CLK = 128;
    localparam int NO_CUT  = 1 << 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic [1:0] br_cfg;

    int tests_run    = 0;
    int tests_failed = 0;
    int ferr_cnt     = 0;
    int ovr_cnt      = 0;

    uart_rx_buf_if rx_if ();

    uart_rx_buf #(
        .DIV0(4), .DIV1(8), .DIV2(16), .DIV3(32), .FIFO_DEPTH(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rxd    (rxd),
        .br_cfg (br_cfg),
        .rx_if  (rx_if)
    );

    always #5 clk = ~clk;

    // Tally error pulses so tests can check how many occurred
    always @(negedge clk) begin
        if (rx_if.frame_err) ferr_cnt <= ferr_cnt + 1;
        if (rx_if.overrun)   ovr_cnt  <= ovr_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives start, 8 data bits LSB first and stop bits,
    // optionally cutting the frame short and returning the line to idle.
    task automatic send_frame(input logic [7:0] b, input int stop_bits,
                              input logic stop_val, input int max_cyc);
        int n = 0;
        for (int i = 0; i < 9 + stop_bits; i++) begin
            if (i == 0)      rxd = 1'b0;
            else if (i < 9)  rxd = b[i-1];
            else             rxd = stop_val;
            for (int c = 0; c < BIT_CLK; c++) begin
                @(negedge clk);
                n++;
                if (n >= max_cyc) begin
                    rxd = 1'b1;
                    return;
                end
            end
        end
        rxd = 1'b1;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check_eq(tag, {24'd0, rx_if.rx_data}, {24'd0, exp});
        rx_if.rd_en = 1'b1;
        @(negedge clk);
        rx_if.rd_en = 1'b0;
    endtask

    initial begin
        repeat (4000000) @(negedge clk);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int fe0;
        int ov0;

        rst = 1'b1; rxd = 1'b1; br_cfg = 2'b01; rx_if.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        check_eq("rst_data",  {24'd0, rx_if.rx_data},  32'd0);
        check_eq("rst_ferr",  {31'd0, rx_if.frame_err}, 32'd0);
        check_eq("rst_ovr",   {31'd0, rx_if.overrun},  32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: single byte, latency = 2 sync + 1 detect + 9.5 bits of ticks
        lat = -1;
        fork
            send_frame(8'h41, 1, 1'b1, NO_CUT);
            begin
                for (int c = 1; c <= 1400; c++) begin
                    @(negedge clk);
                    if (rx_if.rx_valid && lat < 0) lat = c;
                end
            end
        join
        check_eq("t1_latency", lat, 32'd1219);
        check_eq("t1_data", {24'd0, rx_if.rx_data}, 32'h41);
        pop_expect("t1_pop", 8'h41);
        check_eq("t1_empty", {31'd0, rx_if.rx_valid}, 32'd0);

        // 2: 40-cycle glitch is rejected at the mid start-bit sample
        fe0 = ferr_cnt;
        send_frame(8'h00, 1, 1'b1, 40);
        repeat (200) @(negedge clk);
        check_eq("t2_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        check_eq("t2_ferr", ferr_cnt - fe0, 32'd0);

        // 3: stop held low for 3 bits, then a clean frame
        fe0 = ferr_cnt;
        send_frame(8'h5A, 3, 1'b0, NO_CUT);
        repeat (BIT_CLK) @(negedge clk);
        check_eq("t3_ferr", ferr_cnt - fe0, 32'd1);
        check_eq("t3_empty", {31'd0, rx_if.rx_valid}, 32'd0);
        send_frame(8'h33, 1, 1'b1, NO_CUT);
        repeat (64) @(negedge clk);
        check_eq("t3_valid", {31'd0, rx_if.rx_valid}, 32'd1);
        pop_expect("t3_data", 8'h33);

        // 4: five back-to-back bytes into a 4-deep FIFO
        ov0 = ovr_cnt;
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1, 1'b1, NO_CUT);
        repeat (64) @(negedge clk);
        check_eq("t4_overrun", ovr_cnt - ov0, 32'd1);
        pop_expect("t4_pop1", 8'h01);
        pop_expect("t4_pop2", 8'h02);
        pop_expect("t4_pop3", 8'h03);
        pop_expect("t4_pop4", 8'h04);
        check_eq("t4_empty", {31'd0, rx_if.rx_valid}, 32'd0);

        // 5: full FIFO, pop exactly in the stop-sample push cycle
        ov0 = ovr_cnt;
        for (int b = 8'h11; b <= 8'h14; b++) send_frame(8'(b), 1, 1'b1, NO_CUT);
        fork
            send_frame(8'h15, 1, 1'b1, NO_CUT);
            begin
                repeat (1218) @(negedge clk);
                rx_if.rd_en = 1'b1;
                @(negedge clk);
                rx_if.rd_en = 1'b0;
            end
        join
        repeat (64) @(negedge clk);
        check_eq("t5_overrun", ovr_cnt - ov0, 32'd0);
        pop_expect("t5_pop1", 8'h12);
        pop_expect("t5_pop2", 8'h13);
        pop_expect("t5_pop3", 8'h14);
        pop_expect("t5_pop4", 8'h15);
        check_eq("t5_empty", {31'd0, rx_if.rx_valid}, 32'd0);

        // 6: reset during data bit 4 with a byte already buffered
        send_frame(8'hA5, 1, 1'b1, NO_CUT);
        repeat (64) @(negedge clk);
        check_eq("t6_pre_data", {24'd0, rx_if.rx_data}, 32'hA5);
        send_frame(8'h00, 1, 1'b1, 700);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_rst_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        check_eq("t6_rst_data",  {24'd0, rx_if.rx_data},  32'd0);
        check_eq("t6_rst_ferr",  {31'd0, rx_if.frame_err}, 32'd0);
        check_eq("t6_rst_ovr",   {31'd0, rx_if.overrun},  32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send_frame(8'hC3, 1, 1'b1, NO_CUT);
        repeat (64) @(negedge clk);
        pop_expect("t6_data", 8'hC3);
        check_eq("t6_empty", {31'd0, rx_if.rx_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
